// File: rtl/tts_pkg.sv
// Shared state encoding and default sizing for the truth-table scanner.
package tts_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tts_state_e;

  localparam int DEF_N_IN   = 3;
  localparam int DEF_SETTLE = 1;
  localparam int N_COMB     = 2**DEF_N_IN;

  function automatic int settle_w(input int settle);
    return (settle > 0) ? $clog2(settle + 1) : 1;
  endfunction

endpackage

// File: rtl/tts_settle_timer.sv
// Settle down-counter: sample_now is high once SETTLE enabled cycles have
// elapsed since load, then reloads itself on the sampling cycle.
module tts_settle_timer
  import tts_pkg::*;
#(
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic sample_now
);

  localparam int             W      = settle_w(SETTLE);
  localparam logic [W-1:0]   PRESET = W'(SETTLE);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= PRESET;
    end else if (en) begin
      cnt_q <= (cnt_q == '0) ? PRESET : cnt_q - W'(1);
    end
  end

  assign sample_now = (cnt_q == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// Walks a combinational function through every input combination, capturing
// its minterm mask and ones count, then compares against an expected mask.
module truth_table_scanner
  import tts_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2**N_IN-1:0]   expected,
  output logic [N_IN-1:0]      in_vec,
  input  logic                 f_in,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   minterm_mask,
  output logic [N_IN:0]        ones_cnt,
  output logic                 match
);

  localparam int              NC       = 2**N_IN;
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(NC - 1);

  tts_state_e      state_q;
  logic [N_IN-1:0] idx_q;
  logic [N_IN-1:0] in_vec_q;
  logic [NC-1:0]   exp_q;
  logic [NC-1:0]   mask_q;
  logic [NC-1:0]   mask_d;
  logic [N_IN:0]   ones_q;
  logic [N_IN:0]   ones_d;
  logic            busy_q;
  logic            done_q;
  logic            match_q;
  logic            sample_now;
  logic            timer_load;
  logic            timer_en;

  assign timer_load = (state_q == IDLE) && start;
  assign timer_en   = (state_q == RUN) && !abort;

  tts_settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (timer_load),
    .en         (timer_en),
    .sample_now (sample_now)
  );

  // Mask/count including the current sample, so match sees the final bit.
  always_comb begin
    mask_d        = mask_q;
    mask_d[idx_q] = f_in;
    ones_d        = ones_q + {{N_IN{1'b0}}, f_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      in_vec_q <= '0;
      exp_q    <= '0;
      mask_q   <= '0;
      ones_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      match_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q  <= RUN;
            busy_q   <= 1'b1;
            idx_q    <= '0;
            in_vec_q <= '0;
            mask_q   <= '0;
            ones_q   <= '0;
            match_q  <= 1'b0;
            exp_q    <= expected;
          end
        end
        RUN: begin
          if (abort) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            match_q  <= 1'b0;
            in_vec_q <= '0;
          end else if (sample_now) begin
            mask_q <= mask_d;
            ones_q <= ones_d;
            if (idx_q == LAST_IDX) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              match_q <= (mask_d == exp_q);
            end else begin
              idx_q    <= idx_q + N_IN'(1);
              in_vec_q <= idx_q + N_IN'(1);
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_vec       = in_vec_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign minterm_mask = mask_q;
  assign ones_cnt     = ones_q;
  assign match        = match_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: table-driven scans with a result scoreboard,
// plus abort, async-reset and SETTLE=0 sequences.
module tb_truth_table_scanner;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] expected;
  logic [2:0] in_vec;
  logic       f_in;
  logic       busy;
  logic       done;
  logic [7:0] minterm_mask;
  logic [3:0] ones_cnt;
  logic       match;

  logic       start_b;
  logic [7:0] expected_b;
  logic [2:0] in_vec_b;
  logic       f_in_b;
  logic       busy_b;
  logic       done_b;
  logic [7:0] minterm_mask_b;
  logic [3:0] ones_cnt_b;
  logic       match_b;

  logic [7:0] func;
  logic [7:0] func_b;
  int         cyc;
  int         checks;
  int         failures;

  typedef struct {
    logic [7:0] expv;
    logic [7:0] fn;
    int         restart_k;
    bit         with_abort;
    logic [7:0] exp_mask;
    logic [3:0] exp_ones;
    logic       exp_match;
  } vec_t;

  typedef struct {
    logic [7:0] mask;
    logic [3:0] ones;
    logic       match;
  } res_t;

  res_t sb_q[$];
  vec_t vecs[7];

  // Function block under scan: truth table held in func (default m(2,5,6,7)).
  assign f_in   = func[in_vec];
  assign f_in_b = func_b[in_vec_b];

  truth_table_scanner #(.N_IN(3), .SETTLE(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .expected     (expected),
    .in_vec       (in_vec),
    .f_in         (f_in),
    .busy         (busy),
    .done         (done),
    .minterm_mask (minterm_mask),
    .ones_cnt     (ones_cnt),
    .match        (match)
  );

  truth_table_scanner #(.N_IN(3), .SETTLE(0)) dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start_b),
    .abort        (1'b0),
    .expected     (expected_b),
    .in_vec       (in_vec_b),
    .f_in         (f_in_b),
    .busy         (busy_b),
    .done         (done_b),
    .minterm_mask (minterm_mask_b),
    .ones_cnt     (ones_cnt_b),
    .match        (match_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Scoreboard: every done pops the result queued when the scan was started.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 at t=%0t", $time);
      end else begin
        res_t e;
        e = sb_q.pop_front();
        check("sb_mask", minterm_mask, e.mask);
        check("sb_ones", ones_cnt, e.ones);
        check("sb_match", match, e.match);
      end
    end
  end

  task automatic run_scan(input vec_t v);
    int s;
    int k;
    @(negedge clk);
    func     = v.fn;
    expected = v.expv;
    start    = 1'b1;
    abort    = v.with_abort;
    sb_q.push_back('{v.exp_mask, v.exp_ones, v.exp_match});
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    s     = cyc;
    k     = 0;
    check("busy_after_start", busy, 1);
    while (done !== 1'b1 && k < 40) begin
      if (k < 16) begin
        check("in_vec_step", in_vec, k / 2);
        check("busy_running", busy, 1);
      end
      start = (k == v.restart_k);
      @(negedge clk);
      start = 1'b0;
      k = cyc - s;
    end
    check("done_latency", k, 16);
    check("in_vec_at_done", in_vec, 7);
    check("busy_at_done", busy, 0);
    start = (v.restart_k == 16);
    @(negedge clk);
    start = 1'b0;
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
  endtask

  initial begin
    int s;
    int k;
    bit saw_done;
    vec_t v;

    cyc        = 0;
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    expected   = 8'h00;
    func       = 8'hE4;
    start_b    = 1'b0;
    expected_b = 8'h00;
    func_b     = 8'hE4;

    vecs[0] = '{8'hE4, 8'hE4, -1, 1'b0, 8'hE4, 4'd4, 1'b1};
    vecs[1] = '{8'hE5, 8'hE4, -1, 1'b0, 8'hE4, 4'd4, 1'b0};
    vecs[2] = '{8'hE4, 8'hE4,  4, 1'b0, 8'hE4, 4'd4, 1'b1};
    vecs[3] = '{8'h00, 8'h00, -1, 1'b0, 8'h00, 4'd0, 1'b1};
    vecs[4] = '{8'hFF, 8'hFF, 16, 1'b0, 8'hFF, 4'd8, 1'b1};
    vecs[5] = '{8'h81, 8'h81, -1, 1'b1, 8'h81, 4'd2, 1'b1};
    vecs[6] = '{8'hE4, 8'h1B, -1, 1'b0, 8'h1B, 4'd4, 1'b0};

    #2;
    check("rst_in_vec", in_vec, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mask", minterm_mask, 0);
    check("rst_ones", ones_cnt, 0);
    check("rst_match", match, 0);
    check("rst_b_busy", busy_b, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_scan(vecs[i]);
    end

    // Abort at edge 7: f(0..2) already captured at edges 2, 4, 6.
    @(negedge clk);
    func     = 8'hE4;
    expected = 8'hE4;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_match", match, 0);
    check("abort_in_vec", in_vec, 0);
    check("abort_mask", minterm_mask, 8'h04);
    check("abort_ones", ones_cnt, 1);
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("abort_no_done", saw_done, 0);

    // Asynchronous reset between edges 8 and 9.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("pre_reset_in_vec", in_vec, 4);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_in_vec", in_vec, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_mask", minterm_mask, 0);
    check("async_rst_ones", ones_cnt, 0);
    check("async_rst_match", match, 0);
    @(negedge clk);
    rst_n = 1'b1;
    v = vecs[0];
    run_scan(v);
    repeat (3) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);

    // SETTLE=0 build: one sample per cycle, done after edge 8.
    @(negedge clk);
    func_b     = 8'hE4;
    expected_b = 8'hE4;
    start_b    = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    s = cyc;
    k = 0;
    while (done_b !== 1'b1 && k < 30) begin
      if (k < 8) check("b_in_vec_step", in_vec_b, k);
      @(negedge clk);
      k = cyc - s;
    end
    check("b_done_latency", k, 8);
    check("b_mask", minterm_mask_b, 8'hE4);
    check("b_ones", ones_cnt_b, 4);
    check("b_match", match_b, 1);
    @(negedge clk);
    check("b_done_one_cycle", done_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
